// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
// Converts one word-sized burst command at a time into AHB-Lite initiator
// transfers. Address phases are pipelined against data phases, so a burst
// runs without IDLE gaps. A NONSEQ is re-issued whenever the burst crosses a
// 1KB boundary. ERROR responses cancel whatever is left of the burst.
//
// Command handshake: a command is taken at a rising HCLK edge where
// cmd_valid and cmd_ready are both 1. cmd_ready is 1 only while the FSM is
// in IDLE, and cmd_valid is ignored in every other state. The command
// fields are latched at that edge, so the source may change them afterwards.
// wd_data must hold the next write beat for the whole write command.
// wd_pop marks the edge at which that beat was taken.
module ahb_cmd_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [31:0] wd_data,
    output logic        wd_pop,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;
    localparam logic [2:0] HS_WORD   = 3'b010;

    state_t      state, state_nxt;
    logic [3:0]  beats_left, beats_left_nxt;   // address phases still to issue after the current one
    logic        dp_active, dp_active_nxt;     // a data phase is on the bus this cycle
    logic        dp_write, dp_write_nxt;       // direction of that data phase
    logic [31:0] haddr_nxt;
    logic [1:0]  htrans_nxt;
    logic        hwrite_nxt;
    logic [2:0]  hburst_nxt;
    logic [31:0] hwdata_nxt;
    logic [31:0] rd_data_nxt;
    logic        wd_pop_nxt, rd_valid_nxt, done_nxt, err_nxt;
    logic        resp_err;
    logic [31:0] next_addr;

    // Any non-OKAY response (01, 10, 11) counts as an error.
    assign resp_err  = (HRESP != 2'b00);
    assign next_addr = HADDR + 32'd4;
    assign cmd_ready = (state == ST_IDLE);
    assign dbg_state = state;
    // Transfers are always word-sized, so the size is a constant.
    assign HSIZE     = HS_WORD;

    // Next-state and next-output logic; everything holds unless a step below changes it.
    always_comb begin
        state_nxt      = state;
        beats_left_nxt = beats_left;
        dp_active_nxt  = dp_active;
        dp_write_nxt   = dp_write;
        haddr_nxt      = HADDR;
        htrans_nxt     = HTRANS;
        hwrite_nxt     = HWRITE;
        hburst_nxt     = HBURST;
        hwdata_nxt     = HWDATA;
        rd_data_nxt    = rd_data;
        wd_pop_nxt     = 1'b0;
        rd_valid_nxt   = 1'b0;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    haddr_nxt      = {cmd_addr[31:2], 2'b00};
                    htrans_nxt     = HT_NONSEQ;
                    hwrite_nxt     = cmd_write;
                    hburst_nxt     = (cmd_len == 4'd0) ? HB_SINGLE : HB_INCR;
                    beats_left_nxt = cmd_len;
                    dp_active_nxt  = 1'b0;
                    state_nxt      = ST_ADDR;
                end
            end

            ST_ADDR, ST_DATA: begin
                if (dp_active && resp_err) begin
                    // First cycle of a two-cycle error: withdraw any pending beat.
                    htrans_nxt    = HT_IDLE;
                    dp_active_nxt = 1'b0;
                    if (HREADY) begin
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end else if (HREADY) begin
                    if (dp_active && !dp_write) begin
                        rd_data_nxt  = HRDATA;
                        rd_valid_nxt = 1'b1;
                    end
                    if (state == ST_ADDR) begin
                        // Current address phase completes; its data phase starts now.
                        dp_active_nxt = 1'b1;
                        dp_write_nxt  = HWRITE;
                        if (HWRITE) begin
                            hwdata_nxt = wd_data;
                            wd_pop_nxt = 1'b1;
                        end
                        if (beats_left != 4'd0) begin
                            haddr_nxt      = next_addr;
                            htrans_nxt     = (next_addr[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
                            beats_left_nxt = beats_left - 4'd1;
                        end else begin
                            htrans_nxt = HT_IDLE;
                            state_nxt  = ST_DATA;
                        end
                    end else begin
                        dp_active_nxt = 1'b0;
                        done_nxt      = 1'b1;
                        state_nxt     = ST_IDLE;
                    end
                end
            end

            ST_ERR: begin
                if (HREADY) begin
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            beats_left <= 4'd0;
            dp_active  <= 1'b0;
            dp_write   <= 1'b0;
            HADDR      <= 32'd0;
            HTRANS     <= HT_IDLE;
            HWRITE     <= 1'b0;
            HBURST     <= HB_SINGLE;
            HWDATA     <= 32'd0;
            rd_data    <= 32'd0;
            wd_pop     <= 1'b0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            beats_left <= beats_left_nxt;
            dp_active  <= dp_active_nxt;
            dp_write   <= dp_write_nxt;
            HADDR      <= haddr_nxt;
            HTRANS     <= htrans_nxt;
            HWRITE     <= hwrite_nxt;
            HBURST     <= hburst_nxt;
            HWDATA     <= hwdata_nxt;
            rd_data    <= rd_data_nxt;
            wd_pop     <= wd_pop_nxt;
            rd_valid   <= rd_valid_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master
// Directed and randomized bursts against a bench-side AHB slave responder.
// Expected address/transfer-type lists, read data and completion status
// are computed per command from the burst rules (base + 4*i, NONSEQ on
// the first beat and on each 1KB boundary, truncation after an errored beat).
module tb_ahb_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [3:0]  cmd_len = 4'd0;
    logic [31:0] wd_data = 32'd0;
    logic        wd_pop, rd_valid, done, err;
    logic [31:0] rd_data;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [31:0] HRDATA = 32'd0;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;
    logic [1:0]  dbg_state;

    ahb_cmd_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wd_data(wd_data), .wd_pop(wd_pop),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP), .dbg_state(dbg_state)
    );

    // Clock and reset block
    initial forever #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {HTRANS, HADDR} per address phase and expected read beats.
    logic [33:0] exp_ap_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] wd_vals[16];
    logic        exp_err, exp_write;
    logic [2:0]  exp_burst;
    int          wd_idx, hw_idx, ap_cnt, rd_cnt, done_cnt;
    int          cfg_err_beat = -1, cfg_stall_beat = -1;
    bit          cfg_rand = 1'b0;
    logic [1:0]  cfg_resp = 2'b01;

    // Slave-side view of the bus
    logic [1:0]  p_trans = 2'b00;
    logic [31:0] p_addr = 32'd0, p_hwdata = 32'd0;
    logic        p_write = 1'b0;
    logic [2:0]  p_burst = 3'd0, p_size = 3'd0;
    bit          dp_valid = 1'b0, dp_write = 1'b0;
    logic [31:0] dp_addr = 32'd0;
    int          dp_beat = 0, wait_left = 0, err_stage = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Memory contents the slave returns for a read of a word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
    endfunction

    // One slave/monitor step, run at each falling edge.
    task automatic bus_step();
        logic [33:0] e;
        if (!HRESETn) begin
            dp_valid  = 1'b0;
            err_stage = 0;
            wait_left = 0;
            HREADY    = 1'b1;
            HRESP     = 2'b00;
        end else begin
            // Account for the rising edge that just happened.
            if (HREADY) begin
                if (err_stage == 2) begin
                    check("htrans_idle_err2", {38'd0, p_trans}, 40'd0);
                    err_stage = 0;
                end else if (dp_valid && dp_write) begin
                    check("hwdata_beat", {8'd0, p_hwdata}, {8'd0, wd_vals[hw_idx % 16]});
                    hw_idx++;
                end
                if (p_trans[1]) begin
                    check("ap_in_budget", {39'd0, exp_ap_q.size() != 0}, 40'd1);
                    if (exp_ap_q.size() != 0) begin
                        e = exp_ap_q.pop_front();
                        check("ap_addr_trans", {6'd0, p_trans, p_addr}, {6'd0, e});
                        check("ap_hwrite", {39'd0, p_write}, {39'd0, exp_write});
                        check("ap_hsize", {37'd0, p_size}, 40'd2);
                        check("ap_hburst", {37'd0, p_burst}, {37'd0, exp_burst});
                    end
                    dp_valid  = 1'b1;
                    dp_write  = p_write;
                    dp_addr   = p_addr;
                    dp_beat   = ap_cnt;
                    ap_cnt++;
                    wait_left = cfg_rand ? int'($urandom_range(0, 2))
                                         : ((dp_beat == cfg_stall_beat) ? 2 : 0);
                end else begin
                    dp_valid = 1'b0;
                end
            end else if (p_trans[1] && HRESP == 2'b00) begin
                check("stall_hold", {5'd0, HTRANS, HWRITE, HADDR}, {5'd0, p_trans, p_write, p_addr});
            end

            // Pulses produced at that edge.
            if (wd_pop) begin
                check("wd_pop_hwdata", {8'd0, HWDATA}, {8'd0, wd_vals[wd_idx % 16]});
                wd_idx++;
            end
            if (rd_valid) begin
                check("rd_in_budget", {39'd0, exp_q.size() != 0}, 40'd1);
                if (exp_q.size() != 0)
                    check("rd_data", {8'd0, rd_data}, {8'd0, exp_q.pop_front()});
                rd_cnt++;
            end
            if (done) begin
                check("done_err", {39'd0, err}, {39'd0, exp_err});
                check("done_cmd_ready", {39'd0, cmd_ready}, 40'd1);
                done_cnt++;
            end

            // Response for the coming cycle.
            HRESP = 2'b00;
            if (err_stage == 1) begin
                HREADY    = 1'b1;
                HRESP     = cfg_resp;
                err_stage = 2;
            end else if (dp_valid && dp_beat == cfg_err_beat) begin
                HREADY    = 1'b0;
                HRESP     = cfg_resp;
                err_stage = 1;
            end else if (dp_valid && wait_left > 0) begin
                HREADY = 1'b0;
                wait_left--;
            end else begin
                HREADY = 1'b1;
            end
            HRDATA = (dp_valid && !dp_write && HREADY) ? mem_word(dp_addr) : $urandom();
        end
        wd_data  = wd_vals[wd_idx % 16];
        p_trans  = HTRANS;
        p_addr   = HADDR;
        p_write  = HWRITE;
        p_hwdata = HWDATA;
        p_burst  = HBURST;
        p_size   = HSIZE;
    endtask

    task automatic tick();
        @(negedge HCLK);
        bus_step();
    endtask

    // Reference model: expected transfers for one command.
    task automatic setup_cmd(input bit wr, input logic [31:0] addr, input int len,
                             input int eb, input int sb, input bit rnd);
        int n_ap, n_rd;
        logic [31:0] a;
        logic [1:0] t;
        bit errs;
        if (wr) eb = -1;
        errs = (eb >= 0 && eb <= len);
        n_ap = errs ? eb + 1 : len + 1;
        n_rd = wr ? 0 : (errs ? eb : len + 1);
        exp_ap_q.delete();
        exp_q.delete();
        for (int i = 0; i < n_ap; i++) begin
            a = {addr[31:2], 2'b00} + 32'(4 * i);
            t = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
            exp_ap_q.push_back({t, a});
            if (i < n_rd) exp_q.push_back(mem_word(a));
        end
        for (int i = 0; i < 16; i++) wd_vals[i] = $urandom();
        exp_err   = errs;
        exp_write = wr;
        exp_burst = (len == 0) ? 3'd0 : 3'd1;
        cfg_err_beat   = eb;
        cfg_stall_beat = sb;
        cfg_rand       = rnd;
        cfg_resp       = rnd ? 2'($urandom_range(1, 3)) : 2'b01;
        wd_idx = 0; hw_idx = 0; ap_cnt = 0; rd_cnt = 0; done_cnt = 0;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = 4'(len);
    endtask

    // Driver: issue one command and wait (bounded) for its done pulse.
    task automatic run_cmd(input string name, input bit wr, input logic [31:0] addr,
                           input int len, input int eb, input int sb, input bit rnd);
        int cyc;
        bit errs;
        setup_cmd(wr, addr, len, eb, sb, rnd);
        errs = exp_err;
        check({name, "_ready_idle"}, {39'd0, cmd_ready}, 40'd1);
        cmd_valid = 1'b1;
        tick();
        check({name, "_ready_busy"}, {39'd0, cmd_ready}, 40'd0);
        // cmd_valid stays high with junk fields while busy; it must be ignored.
        cmd_write = 1'($urandom());
        cmd_addr  = $urandom();
        cmd_len   = 4'($urandom());
        cyc = 0;
        while (done_cnt == 0 && cyc < 400) begin
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        check({name, "_done_seen"}, {39'd0, done_cnt != 0}, 40'd1);
        tick();
        check({name, "_ap_count"}, 40'(ap_cnt), 40'(errs ? eb + 1 : len + 1));
        check({name, "_pop_count"}, 40'(wd_idx), wr ? 40'(len + 1) : 40'd0);
        check({name, "_hw_count"}, 40'(hw_idx), wr ? 40'(len + 1) : 40'd0);
        check({name, "_rd_count"}, 40'(rd_cnt), wr ? 40'd0 : 40'(errs ? eb : len + 1));
        check({name, "_done_count"}, 40'(done_cnt), 40'd1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_cmd_ready"}, {39'd0, cmd_ready}, 40'd1);
        check({name, "_htrans"}, {38'd0, HTRANS}, 40'd0);
        check({name, "_haddr"}, {8'd0, HADDR}, 40'd0);
        check({name, "_hwrite"}, {39'd0, HWRITE}, 40'd0);
        check({name, "_hsize"}, {37'd0, HSIZE}, 40'd2);
        check({name, "_hburst"}, {37'd0, HBURST}, 40'd0);
        check({name, "_hwdata"}, {8'd0, HWDATA}, 40'd0);
        check({name, "_pulses"}, {36'd0, wd_pop, rd_valid, done, err}, 40'd0);
        check({name, "_rd_data"}, {8'd0, rd_data}, 40'd0);
    endtask

    // Directed sequence, random phase, mid-burst reset, final report.
    initial begin
        int cyc, len, eb;
        bit wr;
        logic [31:0] addr;

        #1 HRESETn = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        #2 HRESETn = 1'b1;
        tick();

        run_cmd("single_write", 1'b1, 32'h0000_0100, 0, -1, -1, 1'b0);
        run_cmd("read4_stall", 1'b0, 32'h0000_0200, 3, -1, 1, 1'b0);
        run_cmd("write4_1kb", 1'b1, 32'h0000_03F8, 3, -1, -1, 1'b0);
        run_cmd("read8_err", 1'b0, 32'h0000_0500, 7, 2, -1, 1'b0);
        run_cmd("read1_err", 1'b0, 32'h0000_0603, 0, 0, -1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            wr   = 1'($urandom_range(0, 1));
            len  = int'($urandom_range(0, 15));
            addr = $urandom();
            if ($urandom_range(0, 1) == 1)
                addr = (addr & 32'hFFFF_FC00) | (32'h3C0 + $urandom_range(0, 63));
            eb = (!wr && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
            run_cmd("random", wr, addr, len, eb, -1, 1'b1);
        end

        // Reset asserted during beat 2 of a 16-beat write.
        setup_cmd(1'b1, 32'h0000_1000, 15, -1, -1, 1'b0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cyc = 0;
        while (ap_cnt < 2 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("midreset_reached_beat2", {39'd0, ap_cnt >= 2}, 40'd1);
        #2 HRESETn = 1'b0;
        #1 check_reset_values("midreset");
        tick();
        tick();
        #2 HRESETn = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) tick();
        check("midreset_no_done", 40'(done_cnt), 40'd0);
        check("midreset_ready_after", {39'd0, cmd_ready}, 40'd1);
        check("midreset_htrans_after", {38'd0, HTRANS}, 40'd0);
        run_cmd("after_reset", 1'b0, 32'h0000_2000, 5, -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have no parameters; address and data widths are fixed at 32 bits and transfers are word-sized only.
REQ-002 SHALL have port HCLK  input  1  AHB system clock; all state updates on the rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready are both high at a rising edge.
REQ-006 SHALL have port cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have port cmd_addr  input  32  start byte address; bits [1:0] are ignored and treated as 00.
REQ-008 SHALL have port cmd_len  input  4  number of beats minus 1 (0 = 1 beat, 15 = 16 beats).
REQ-009 SHALL have port wd_data  input  32  write data for the next write beat; must be valid whenever the block is in a write command.
REQ-010 SHALL have port wd_pop  output  1  one-cycle pulse: wd_data consumed at this edge.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse: rd_data holds one read beat.
REQ-012 SHALL have port rd_data  output  32  registered read data.
REQ-013 SHALL have port done  output  1  one-cycle pulse: command finished.
REQ-014 SHALL have port err  output  1  qualifies done; 1 = an ERROR response was received.
REQ-015 SHALL have ports HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HWDATA out 32, HRDATA in 32, HREADY in 1, HRESP in 2 (00 OKAY, 01 ERROR); these are AHB-Lite initiator signals.

Function
REQ-016 SHALL implement the FSM states IDLE, ADDR, DATA and ERR; cmd_ready SHALL be 1 only in IDLE.
REQ-017 SHALL, on acceptance in IDLE, latch the command and drive NONSEQ on the next cycle, with HADDR = {cmd_addr[31:2],2'b00}, HWRITE = cmd_write, HSIZE = 3'b010, and HBURST = 000 if cmd_len = 0, else 001 (INCR).
REQ-018 SHALL register all AHB outputs; an address phase completes only at an edge where HREADY = 1, and HADDR, HTRANS and HWRITE SHALL be held stable while HREADY = 0.
REQ-019 SHALL, when an address phase completes and more beats remain, present the next beat at HADDR+4 with HTRANS = SEQ, overlapping the previous beat's data phase (pipelined; no IDLE gaps).
REQ-020 SHALL use HTRANS = NONSEQ instead of SEQ when HADDR+4 has bits [9:0] = 0 (1KB boundary crossing); HBURST SHALL stay INCR.
REQ-021 SHALL, when the final address phase completes, drive HTRANS = IDLE and move to DATA until the last data phase completes.
REQ-022 SHALL, for writes, pulse wd_pop and load HWDATA <= wd_data at each edge where a write address phase completes; HWDATA SHALL be held through wait states.
REQ-023 SHALL, for reads, set rd_data <= HRDATA and pulse rd_valid on the cycle after each edge where a read data phase completes with HREADY = 1 and HRESP = OKAY.
REQ-024 SHALL, on HRESP = 01 with HREADY = 0 (first error cycle), drive HTRANS = IDLE in the second error cycle, cancel all remaining beats, issue no wd_pop or rd_valid for the errored beat, and enter ERR.
REQ-025 SHALL, in ERR, wait for HREADY = 1 (second error cycle), then pulse done with err = 1 and return to IDLE.
REQ-026 SHALL, on normal completion, pulse done with err = 0 in the cycle after the last data phase completes; FSM is in IDLE (cmd_ready = 1) during that same cycle.
REQ-027 SHALL treat HRESP values 10 and 11 as ERROR.
REQ-028 SHALL ignore cmd_valid while not in IDLE; back-to-back commands SHALL have at least the done cycle between them.

Reset
REQ-029 SHALL, while HRESETn = 0, immediately force: FSM = IDLE, HTRANS = 00, HADDR = 0, HWRITE = 0, HSIZE = 010, HBURST = 000, HWDATA = 0, cmd_ready = 1, wd_pop = 0, rd_valid = 0, rd_data = 0, done = 0, err = 0.
REQ-030 SHALL, on reset asserted mid-burst, abandon the command with no done pulse; the first command after reset SHALL start cleanly.

Verification
REQ-031 SHALL pass: single write, addr 0x100, wd_data 0xA5A5A5A5, HREADY = 1 -> one NONSEQ at 0x100, HBURST 000, HWDATA 0xA5A5A5A5 next cycle, one wd_pop, done with err = 0.
REQ-032 SHALL pass: 4-beat read at 0x200 with HREADY low for 2 cycles on beat 2 -> HADDR 0x200/204/208/20C as NONSEQ,SEQ,SEQ,SEQ, address held during the stall, 4 rd_valid pulses in order, done with err = 0.
REQ-033 SHALL pass: 4-beat write at 0x3F8 -> beats at 0x3F8 SEQ-chain, with 0x400 issued as NONSEQ, 4 wd_pop pulses.
REQ-034 SHALL pass: 8-beat read with HRESP = 01 on beat 3 (two-cycle ERROR) -> HTRANS = IDLE in the second error cycle, no further beats, 2 rd_valid pulses, done with err = 1.
REQ-035 SHALL pass: HRESETn asserted during beat 2 of a 16-beat write -> outputs take reset values asynchronously, no done pulse, cmd_ready = 1 after release.
